// File: rtl/selector_2bits_readeasy.sv
// 4:1 data selector with a registered select-change strobe.
// Define SELECTOR_2BITS_READEASY_REG_OUT_EN to register result (1-cycle latency).
module selector_2bits_readeasy #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  input  logic [WIDTH-1:0] number3,
  input  logic [WIDTH-1:0] number4,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             sel_change
);

  localparam int unsigned SEL_W = 2;

  logic [WIDTH-1:0] pick_c;
  logic [SEL_W-1:0] sel_prev_d, sel_prev_q;
  logic             sel_change_d, sel_change_q;

  // Every select code maps to an input, so no fallback path exists.
  always_comb begin
    case (select)
      2'd0: pick_c = number1;
      2'd1: pick_c = number2;
      2'd2: pick_c = number3;
      2'd3: pick_c = number4;
    endcase
  end

  // Reset is folded in here so it only takes effect on a clock edge.
  always_comb begin
    sel_prev_d   = select;
    sel_change_d = (select != sel_prev_q);
    if (!reset) begin
      sel_prev_d   = SEL_W'(0);
      sel_change_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    sel_prev_q   <= sel_prev_d;
    sel_change_q <= sel_change_d;
  end

  assign sel_change = sel_change_q;

`ifdef SELECTOR_2BITS_READEASY_REG_OUT_EN
  logic [WIDTH-1:0] result_d, result_q;

  always_comb begin
    result_d = pick_c;
    if (!reset) begin
      result_d = WIDTH'(0);
    end
  end

  always_ff @(posedge clk) begin
    result_q <= result_d;
  end

  assign result = result_q;
`else
  assign result = pick_c;
`endif

endmodule

// File: tb/tb_selector_2bits_readeasy.sv
// Self-checking bench for selector_2bits_readeasy: directed cases plus random
// stimulus against a behavioural model built from a select history and a data table.
module tb_selector_2bits_readeasy;

  logic        clk;
  logic        reset;
  logic [7:0]  number1, number2, number3, number4;
  logic [1:0]  select;
  logic [7:0]  result;
  logic        sel_change;

  logic [15:0] n16_1, n16_2, n16_3, n16_4;
  logic [1:0]  sel16;
  logic [15:0] result16;
  logic        sel_change16;

  int checks = 0;
  int errors = 0;

  logic [1:0] sel_hist[$];
  logic [7:0] exp_res_reg;

  selector_2bits_readeasy #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .number1(number1), .number2(number2), .number3(number3), .number4(number4),
    .select(select), .result(result), .sel_change(sel_change)
  );

  selector_2bits_readeasy #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .number1(n16_1), .number2(n16_2), .number3(n16_3), .number4(n16_4),
    .select(sel16), .result(result16), .sel_change(sel_change16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, check the combinational view, then the post-edge view.
  task automatic step(input logic rst, input logic [1:0] s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input string tag);
    logic [7:0] table_v[4];
    logic       exp_chg;
    table_v[0] = a; table_v[1] = b; table_v[2] = c; table_v[3] = d;
    reset = rst; select = s;
    number1 = a; number2 = b; number3 = c; number4 = d;
    #1;
`ifndef SELECTOR_2BITS_READEASY_REG_OUT_EN
    chk({tag, "_result"}, 16'(result), 16'(table_v[s]));
`endif
    @(posedge clk);
    if (!rst) begin
      exp_chg     = 1'b0;
      exp_res_reg = 8'h00;
      sel_hist.push_back(2'd0);
    end else begin
      exp_chg     = (s != sel_hist[$]);
      exp_res_reg = table_v[s];
      sel_hist.push_back(s);
    end
    #1;
    chk({tag, "_sel_change"}, 16'(sel_change), 16'(exp_chg));
`ifdef SELECTOR_2BITS_READEASY_REG_OUT_EN
    chk({tag, "_result_reg"}, 16'(result), 16'(exp_res_reg));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_hist.push_back(2'd0);
    n16_1 = 16'h1111; n16_2 = 16'h2222; n16_3 = 16'h3333; n16_4 = 16'hBEEF;
    sel16 = 2'd3;

    // Reset state
    step(1'b0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "reset");
    step(1'b0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "reset");

    // Stepping select through all codes, including the 3 -> 0 wrap
    step(1'b1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "inc0");
    step(1'b1, 2'd1, 8'h01, 8'h02, 8'h03, 8'h04, "inc1");
    step(1'b1, 2'd2, 8'h01, 8'h02, 8'h03, 8'h04, "inc2");
    step(1'b1, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, "inc3");
    step(1'b1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "wrap0");
    step(1'b1, 2'd1, 8'h01, 8'h02, 8'h03, 8'h04, "wrap1");

    // Select held at 2
    for (int i = 0; i < 6; i++)
      step(1'b1, 2'd2, 8'h01, 8'h02, 8'h03, 8'h04, "hold2");

    // Data changes under a fixed select
    step(1'b1, 2'd1, 8'h11, 8'hAA, 8'h33, 8'h44, "track_aa");
    step(1'b1, 2'd1, 8'h11, 8'hAA, 8'h33, 8'h44, "track_aa2");
    step(1'b1, 2'd1, 8'h11, 8'h55, 8'h33, 8'h44, "track_55");
    step(1'b1, 2'd1, 8'h11, 8'h55, 8'h33, 8'h44, "track_55b");

    // Reset with select = 3, then release with select still 3
    step(1'b0, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, "rst_sel3");
    step(1'b0, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, "rst_sel3b");
    step(1'b1, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, "rel_sel3");
    step(1'b1, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, "rel_hold3");

    // Mid-operation reset overrides a pending change
    step(1'b1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "pre_mid");
    step(1'b0, 2'd2, 8'h01, 8'h02, 8'h03, 8'h04, "mid_rst");
    step(1'b1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "post_mid");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(9) != 0), 2'($urandom_range(3)),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
    end

    // Wide instance
    step(1'b1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "w16_settle");
    step(1'b1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, "w16_settle2");
    chk("w16_result", result16, 16'hBEEF);
    chk("w16_sel_change", 16'(sel_change16), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/selector_2bits_readeasy.md
SELECTOR_2BITS_READEASY -- requirements
Module: selector_2bits_readeasy

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each input and of the result.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all registers.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port number1, input, WIDTH bits: data selected when select = 2'd0.
REQ-005 The block SHALL have port number2, input, WIDTH bits: data selected when select = 2'd1.
REQ-006 The block SHALL have port number3, input, WIDTH bits: data selected when select = 2'd2.
REQ-007 The block SHALL have port number4, input, WIDTH bits: data selected when select = 2'd3.
REQ-008 The block SHALL have port select, input, 2 bits: source index.
REQ-009 The block SHALL have port result, output, WIDTH bits: selected data.
REQ-010 The block SHALL have port sel_change, output, 1 bit: registered one-cycle strobe marking a change of select.

Function
REQ-011 The block SHALL drive result = number1/number2/number3/number4 for select = 0/1/2/3 respectively; all four codes are valid, with no default or X path.
REQ-012 The block SHALL pass the selected data bit-exact, with no arithmetic, truncation or extension.
REQ-013 The block SHALL hold a registered copy sel_prev of select, updated every rising clk edge when reset = 1.
REQ-014 The block SHALL assert sel_change for exactly one cycle after a clock edge at which select != sel_prev, and deassert it otherwise.
REQ-015 The block SHALL assert sel_change for one cycle on each step of a continuously incrementing select, including the wrap 3 -> 0.
REQ-016 The block SHALL keep sel_change low while select is held constant.
REQ-017 Without the macro of REQ-023, result SHALL be purely combinational: zero latency, follows select and data inputs within the same cycle, and is independent of clk and reset.

Reset
REQ-018 Reset SHALL be sampled only on a rising clk edge while reset = 0.
REQ-019 While in reset, the block SHALL hold sel_prev = 2'd0 and sel_change = 0.
REQ-020 After reset release, the block SHALL NOT flag a change on the first edge if select = 0.
REQ-021 After reset release, the block SHALL flag a change on the first edge if select != 0.
REQ-022 Reset asserted mid-operation SHALL clear all registers at the next edge, overriding any pending change.

Configuration
REQ-023 With macro SELECTOR_2BITS_READEASY_REG_OUT_EN defined, result SHALL be a register loaded each rising clk edge with the REQ-011 selection, giving 1-cycle latency, with reset value 0 while reset = 0.
REQ-024 With SELECTOR_2BITS_READEASY_REG_OUT_EN undefined, result SHALL follow REQ-017, and sel_change behaviour SHALL be identical in both builds.

Verification
REQ-025 The bench SHALL cover: number1..4 = 8'h01, 8'h02, 8'h03, 8'h04, select stepped 0, 1, 2, 3 -> result = 8'h01, 8'h02, 8'h03, 8'h04 (same cycle without macro, next cycle with macro).
REQ-026 The bench SHALL cover: select incremented every clock from 0 after reset release through 3 -> 0 -> 1 -> sel_change high every cycle after the first step, including the wrap.
REQ-027 The bench SHALL cover: select held at 2 for 5 cycles -> sel_change = 0 throughout; result = number3 throughout.
REQ-028 The bench SHALL cover: reset = 0 for 2 edges with select = 3 -> sel_change = 0 (and result = 8'h00 with macro); on release with select still 3 -> sel_change = 1 on the first edge.
REQ-029 The bench SHALL cover: select = 1 while number2 changes 8'hAA -> 8'h55 -> result tracks it (same cycle without macro, next cycle with macro) and sel_change stays 0.
REQ-030 The bench SHALL cover: WIDTH = 16, number4 = 16'hBEEF, select = 3 -> result = 16'hBEEF.
